// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio decimator datapath.
package audio_pkg;

  localparam int AUDIO_CH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCALE,
    ST_FILTER,
    ST_EMIT
  } audio_dec_state_t;

  // Clamp a signed value into the range of a w-bit two's-complement word.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/audio_rate_tick.sv
// Fractional-N rate generator: one-cycle tick averaging SAMPLE_RATE_HZ per second of clk.
module audio_rate_tick #(
  parameter int unsigned CLK_FREQ_HZ    = 27_000_000,
  parameter int unsigned SAMPLE_RATE_HZ = 48_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  logic [31:0] acc_q, acc_d, acc_sum;
  logic        tick_q, tick_d;

  // Add the sample rate each clock; wrap by the clock rate and flag the wrap.
  always_comb begin
    acc_sum = acc_q + SAMPLE_RATE_HZ;
    acc_d   = acc_sum;
    tick_d  = 1'b0;
    if (acc_sum >= CLK_FREQ_HZ) begin
      acc_d  = acc_sum - CLK_FREQ_HZ;
      tick_d = 1'b1;
    end
  end

  // Accumulator and registered tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/audio_decimator.sv
// Stereo box-car decimator with optional leaky-integrator DC removal.
// Both channels share one FSM and move through the pipeline in lockstep.
module audio_decimator import audio_pkg::*; #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int CLK_FREQ_HZ     = 27_000_000,
  parameter int SAMPLE_RATE_HZ  = 48_000,
  parameter int AVG_LOG2        = 8,
  parameter int DC_SHIFT        = 10
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [AUDIO_CH-1:0][AUDIO_BIT_WIDTH-1:0]  audio_sample_word,
  input  logic                                      dc_block_en,
  input  logic                                      mute,
  // each lane is a two's-complement sample
  output logic [AUDIO_CH-1:0][AUDIO_BIT_WIDTH-1:0]  pcm_out,
  output logic                                      pcm_valid,
  output logic                                      overrun
);

  localparam int W  = AUDIO_BIT_WIDTH;
  localparam int SW = W + AVG_LOG2;      // window sum
  localparam int XW = W + 1;             // offset-removed average
  localparam int YW = W + 3;             // filter output before clamping
  localparam int DW = W + DC_SHIFT + 2;  // DC estimate
  localparam logic [XW-1:0] MIDSCALE = XW'(1) << (W - 1);

  logic                tick;
  audio_dec_state_t    state_q, state_d;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  audio_rate_tick #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .SAMPLE_RATE_HZ(SAMPLE_RATE_HZ)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Sequencing: wait for a tick, accumulate the window, then scale/filter/emit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    // a tick that finds the FSM busy is dropped and latched as an overrun
    ovr_d   = ovr_q | (tick && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: if (tick) begin
        cnt_d   = '0;
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_SCALE;
      end
      ST_SCALE:  state_d = ST_FILTER;
      ST_FILTER: state_d = ST_EMIT;
      ST_EMIT: begin
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state, window counter and output flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pcm_valid = valid_q;
  assign overrun   = ovr_q;

  for (genvar c = 0; c < AUDIO_CH; c++) begin : g_ch
    logic [SW-1:0]        sum_q, sum_d;
    logic signed [XW-1:0] x_q, x_d;
    logic signed [YW-1:0] y_full;
    logic signed [W-1:0]  ysat_q, ysat_d;
    logic signed [DW-1:0] dc_q, dc_d;
    logic [W-1:0]         pcm_q, pcm_d;

    // Per-channel datapath stepped by the shared FSM state.
    always_comb begin
      sum_d  = sum_q;
      x_d    = x_q;
      ysat_d = ysat_q;
      dc_d   = dc_q;
      pcm_d  = pcm_q;
      y_full = dc_block_en ? (YW'(x_q) - YW'(dc_q >>> DC_SHIFT)) : YW'(x_q);
      case (state_q)
        ST_IDLE:   if (tick) sum_d = '0;
        ST_ACCUM:  sum_d = sum_q + SW'(audio_sample_word[c]);
        ST_SCALE:  x_d = $signed({1'b0, sum_q[SW-1 -: W]} - MIDSCALE);
        ST_FILTER: begin
          ysat_d = W'(sat_signed(32'(y_full), W));
          // the estimate integrates the unclamped output so it keeps tracking
          // the true DC even while the output is pinned at a rail
          if (dc_block_en) dc_d = dc_q + DW'(y_full);
        end
        // mute only gates the output; the DC estimate above keeps running
        ST_EMIT:   pcm_d = mute ? '0 : ysat_q;
        default:   ;
      endcase
    end

    // Per-channel registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sum_q  <= '0;
        x_q    <= '0;
        ysat_q <= '0;
        dc_q   <= '0;
        pcm_q  <= '0;
      end else begin
        sum_q  <= sum_d;
        x_q    <= x_d;
        ysat_q <= ysat_d;
        dc_q   <= dc_d;
        pcm_q  <= pcm_d;
      end
    end

    assign pcm_out[c] = pcm_q;
  end

endmodule
